cpu_sequencer: RTL

Multi-cycle fetch/decode/execute/writeback sequencer for the mini CPU.
- Fetches 8-bit instructions over a req/ready instruction-memory handshake.
- Holds each instruction in an instruction register (IR) and drives the ALU opcode (alu_op = opcode, straight into the control unit/ALU path), register-file addresses and the register write strobe.
- Maintains the PC and a retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle fetch/decode/execute/writeback sequencer for the
//            mini CPU. Optional single-step mode: CPU_SEQ_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [7:0]       imem_data,
  output logic [2:0]       alu_op,
  output logic [1:0]       rd_addr,
  output logic [1:0]       rs_addr,
  output logic             reg_we,
  output logic             halted,
  output logic             busy,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd6;
`endif

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = ir_q[0] ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      S_WB:     state_d = S_PAUSE;
      S_PAUSE:  if (step) state_d = S_FETCH;
`else
      S_WB:     state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates: IR only on an accepted fetch, pc/count only at writeback.
  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (state_q == S_FETCH && imem_ready) begin
      ir_d = imem_data;
    end
    if (state_q == S_WB) begin
      pc_d = pc_q + PC_ONE;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    imem_req = 1'b0;
    reg_we   = 1'b0;
    halted   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_FETCH:  begin imem_req = 1'b1; busy = 1'b1; end
      S_DECODE: busy = 1'b1;
      S_EXEC:   busy = 1'b1;
      S_WB:     begin reg_we = 1'b1; busy = 1'b1; end
`ifdef CPU_SEQ_SINGLE_STEP_EN
      S_PAUSE:  busy = 1'b1;
`endif
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign alu_op      = ir_q[7:5];
  assign rd_addr     = ir_q[4:3];
  assign rs_addr     = ir_q[2:1];

endmodule

`default_nettype wire
